boot_mailbox_loader: RTL and testbench

Boot-time sequencer that fetches the signed-image header from boot ROM and streams it into the signature-check mailbox. It issues the CTRL start write, polls mailbox status until done, and sets a sticky pass/fail verdict plus the LOCK strobe. It sits between the boot ROM read port and the signature mailbox MMIO write port. Its verdict gates CPU reset release.

---
 rtl/boot_mailbox_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_boot_mailbox_loader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mailbox_loader.sv
// Boot-time loader: streams the signed image header from boot ROM into the
// signature mailbox, kicks the check and latches a sticky pass/fail verdict.
module boot_mailbox_loader #(
  parameter logic [31:0] HDR_BASE    = 32'h0000_0000,
  parameter logic [31:0] MAGIC       = 32'h4856_4F53,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  input  logic        rom_err_i,
  output logic        mb_wr_en_o,
  output logic [31:0] mb_wr_data_o,
  input  logic [31:0] mb_rd_data_i,
  output logic        busy_o,
  output logic        boot_ok_o,
  output logic        boot_fail_o,
  output logic [2:0]  err_code_o,
  output logic        lock_o
);

  localparam int unsigned   CW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TIMER_ONE  = CW'(1);
  localparam logic [5:0]    LAST_IDX   = 6'd32;
  localparam logic [31:0]   CTRL_START = 32'h0000_0001;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_MAGIC   = 3'd1;
  localparam logic [2:0] ERR_SIG     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_ROM     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_START = 3'd4,
    S_POLL  = 3'd5,
    S_PASS  = 3'd6,
    S_FAIL  = 3'd7
  } state_e;

  function automatic logic is_busy(input state_e s);
    logic b;
    case (s)
      S_REQ, S_WAIT, S_WRITE, S_START, S_POLL: b = 1'b1;
      default:                                 b = 1'b0;
    endcase
    return b;
  endfunction

  state_e        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    err_q, err_d;

  logic          rom_req_q, rom_req_d;
  logic [31:0]   rom_addr_q, rom_addr_d;
  logic          mb_wr_en_q, mb_wr_en_d;
  logic [31:0]   mb_wr_data_q, mb_wr_data_d;
  logic          busy_q, busy_d;
  logic          ok_q, ok_d;
  logic          fail_q, fail_d;
  logic          lock_q, lock_d;

  logic          timer_expired_s;
  logic          mb_done_s;
  logic          mb_ok_s;
  logic          unused_status_s;

  // Saturating compare: once a decision beats expiry, the very next busy cycle still times out.
  assign timer_expired_s = is_busy(state_q) && (timer_q >= TIMER_LAST);
  assign mb_done_s       = mb_rd_data_i[31];
  assign mb_ok_s         = mb_rd_data_i[30];
  assign unused_status_s = ^mb_rd_data_i[29:0];

  // Next-state logic for the sequencer, the word index, the timer and the latched word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    if (is_busy(state_q)) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = timer_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = 6'd0;
          timer_d = {CW{1'b0}};
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (timer_expired_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A returned read is decided even if the timer expires in the same cycle.
        if (rom_rvalid_i) begin
          if (rom_err_i) begin
            err_d   = ERR_ROM;
            state_d = S_FAIL;
          end else if ((idx_q == 6'd0) && (rom_rdata_i != MAGIC)) begin
            err_d   = ERR_MAGIC;
            state_d = S_FAIL;
          end else if (idx_q == 6'd0) begin
            idx_d   = 6'd1;
            state_d = S_REQ;
          end else begin
            data_d  = rom_rdata_i;
            state_d = S_WRITE;
          end
        end else if (timer_expired_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WRITE: begin
        if (timer_expired_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_START;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = S_REQ;
        end
      end
      S_START: begin
        if (timer_expired_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else begin
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (mb_done_s) begin
          if (mb_ok_s) begin
            err_d   = ERR_NONE;
            state_d = S_PASS;
          end else begin
            err_d   = ERR_SIG;
            state_d = S_FAIL;
          end
        end else if (timer_expired_s) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FAIL;
        end else begin
          state_d = S_POLL;
        end
      end
      S_PASS: begin
        state_d = S_PASS;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, so every port comes straight from a flop.
  always_comb begin
    rom_req_d  = (state_d == S_REQ);
    mb_wr_en_d = (state_d == S_WRITE) || (state_d == S_START);
    busy_d     = is_busy(state_d);
    ok_d       = (state_d == S_PASS);
    fail_d     = (state_d == S_FAIL);
    lock_d     = (state_d == S_PASS) || (state_d == S_FAIL);

    if (rom_req_d) begin
      rom_addr_d = HDR_BASE + {24'h00_0000, idx_d, 2'b00};
    end else begin
      rom_addr_d = 32'h0000_0000;
    end

    if (state_d == S_WRITE) begin
      mb_wr_data_d = data_d;
    end else if (state_d == S_START) begin
      mb_wr_data_d = CTRL_START;
    end else begin
      mb_wr_data_d = 32'h0000_0000;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= 6'd0;
      timer_q      <= {CW{1'b0}};
      data_q       <= 32'h0000_0000;
      err_q        <= ERR_NONE;
      rom_req_q    <= 1'b0;
      rom_addr_q   <= 32'h0000_0000;
      mb_wr_en_q   <= 1'b0;
      mb_wr_data_q <= 32'h0000_0000;
      busy_q       <= 1'b0;
      ok_q         <= 1'b0;
      fail_q       <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      err_q        <= err_d;
      rom_req_q    <= rom_req_d;
      rom_addr_q   <= rom_addr_d;
      mb_wr_en_q   <= mb_wr_en_d;
      mb_wr_data_q <= mb_wr_data_d;
      busy_q       <= busy_d;
      ok_q         <= ok_d;
      fail_q       <= fail_d;
      lock_q       <= lock_d;
    end
  end

  assign rom_req_o    = rom_req_q;
  assign rom_addr_o   = rom_addr_q;
  assign mb_wr_en_o   = mb_wr_en_q;
  assign mb_wr_data_o = mb_wr_data_q;
  assign busy_o       = busy_q;
  assign boot_ok_o    = ok_q;
  assign boot_fail_o  = fail_q;
  assign err_code_o   = err_q;
  assign lock_o       = lock_q;

endmodule

// File: tb/tb_boot_mailbox_loader.sv
// Directed bench for boot_mailbox_loader: a ROM model and a mailbox model on
// the falling edge, one task per scenario, default and short-timeout instances.
module tb_boot_mailbox_loader;

  localparam logic [31:0] MAGIC = 32'h4856_4F53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_t = 1'b0;
  logic        rom_rvalid_i = 1'b0;
  logic [31:0] rom_rdata_i = 32'h0;
  logic        rom_err_i = 1'b0;
  logic [31:0] mb_rd_data_i = 32'h0;

  logic        a_req, a_wr, a_busy, a_ok, a_fail, a_lock;
  logic [31:0] a_addr, a_wdata;
  logic [2:0]  a_err;
  logic        t_req, t_wr, t_busy, t_ok, t_fail, t_lock;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_err;

  always #5 clk = ~clk;

  boot_mailbox_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .rom_req_o(a_req), .rom_addr_o(a_addr), .rom_rvalid_i(rom_rvalid_i),
    .rom_rdata_i(rom_rdata_i), .rom_err_i(rom_err_i),
    .mb_wr_en_o(a_wr), .mb_wr_data_o(a_wdata), .mb_rd_data_i(mb_rd_data_i),
    .busy_o(a_busy), .boot_ok_o(a_ok), .boot_fail_o(a_fail),
    .err_code_o(a_err), .lock_o(a_lock)
  );

  boot_mailbox_loader #(.TIMEOUT_CYC(200)) u_dut_t (
    .clk(clk), .rst_n(rst_n), .start_i(start_t),
    .rom_req_o(t_req), .rom_addr_o(t_addr), .rom_rvalid_i(rom_rvalid_i),
    .rom_rdata_i(rom_rdata_i), .rom_err_i(rom_err_i),
    .mb_wr_en_o(t_wr), .mb_wr_data_o(t_wdata), .mb_rd_data_i(mb_rd_data_i),
    .busy_o(t_busy), .boot_ok_o(t_ok), .boot_fail_o(t_fail),
    .err_code_o(t_err), .lock_o(t_lock)
  );

  // Scenario configuration (written by the tasks only)
  logic        sel_t = 1'b0;
  int          mb_delay = -1;
  bit          mb_ok = 1'b1;
  int          err_idx = -1;
  bit          rand_lat = 1'b0;
  bit          spur_en = 1'b0;
  logic [31:0] magic_word = MAGIC;

  // Model state (written by the model only)
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          req_cnt = 0;
  int          wr_cnt = 0;
  int          wr_since_rst = 0;
  bit          mb_armed = 1'b0;
  int          mb_cnt = 0;
  logic [31:0] req_log [0:1023];
  logic [31:0] wr_log  [0:1023];

  int vec = 0;
  int miss = 0;

  logic        m_req, m_wr, m_ok, m_fail;
  logic [31:0] m_addr, m_wdata;
  assign m_req   = sel_t ? t_req   : a_req;
  assign m_wr    = sel_t ? t_wr    : a_wr;
  assign m_ok    = sel_t ? t_ok    : a_ok;
  assign m_fail  = sel_t ? t_fail  : a_fail;
  assign m_addr  = sel_t ? t_addr  : a_addr;
  assign m_wdata = sel_t ? t_wdata : a_wdata;

  function automatic logic [31:0] rom_word(input int idx);
    if (idx == 0) return magic_word;
    return 32'h1357_0000 ^ (32'(idx) * 32'h0101_0011);
  endfunction

  // ROM and mailbox models, sampled and driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      rom_rvalid_i = 1'b0;
      rom_err_i = 1'b0;
      mb_rd_data_i = 32'h0;
      mb_armed = 1'b0;
      wr_since_rst = 0;
    end else begin
      rom_rvalid_i = 1'b0;
      rom_err_i = 1'b0;
      if (pend) begin
        if (pend_cnt <= 1) begin
          rom_rvalid_i = 1'b1;
          rom_rdata_i = rom_word(int'(pend_addr[31:2]));
          rom_err_i = (int'(pend_addr[31:2]) == err_idx);
          pend = 1'b0;
        end else begin
          pend_cnt = pend_cnt - 1;
        end
      end else if (spur_en) begin
        rom_rvalid_i = 1'b1;
        rom_rdata_i = 32'hBAD0_BAD0;
      end
      if (m_req) begin
        pend = 1'b1;
        pend_cnt = rand_lat ? int'($urandom_range(7, 1)) : 1;
        pend_addr = m_addr;
        req_log[req_cnt] = m_addr;
        req_cnt = req_cnt + 1;
      end
      if (m_wr) begin
        wr_log[wr_cnt] = m_wdata;
        wr_cnt = wr_cnt + 1;
        wr_since_rst = wr_since_rst + 1;
        if (wr_since_rst == 33 && mb_delay >= 0) begin
          mb_armed = 1'b1;
          mb_cnt = mb_delay;
        end
      end else if (mb_armed) begin
        mb_cnt = mb_cnt - 1;
        if (mb_cnt <= 0) begin
          mb_rd_data_i = {1'b1, mb_ok, 30'h0};
          mb_armed = 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input bit t);
    rst_n = 1'b0;
    start_a = 1'b0;
    start_t = 1'b0;
    sel_t = t;
    mb_delay = -1;
    mb_ok = 1'b1;
    err_idx = -1;
    rand_lat = 1'b0;
    spur_en = 1'b0;
    magic_word = MAGIC;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic kick();
    @(posedge clk); #1;
    if (sel_t) start_t = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_t = 1'b0;
  endtask

  task automatic wait_verdict(input int budget, output bit seen, output int cyc);
    seen = 1'b0;
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (m_ok || m_fail) begin
        seen = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vec++;
    if ({a_busy, a_ok, a_fail, a_err, a_lock, a_req, a_wr} !== 9'b0) begin
      miss++; $display("FAIL reset_ctl_a: got %b want 000000000", {a_busy, a_ok, a_fail, a_err, a_lock, a_req, a_wr});
    end
    vec++;
    if ({a_addr, a_wdata} !== 64'h0) begin
      miss++; $display("FAIL reset_data_a: got %h want 0", {a_addr, a_wdata});
    end
    vec++;
    if ({t_busy, t_ok, t_fail, t_err, t_lock, t_req, t_wr} !== 9'b0) begin
      miss++; $display("FAIL reset_ctl_t: got %b want 000000000", {t_busy, t_ok, t_fail, t_err, t_lock, t_req, t_wr});
    end
  endtask

  task automatic test_happy();
    bit seen; int cyc; int br; int bw;
    do_reset(1'b0);
    mb_delay = 10;
    br = req_cnt; bw = wr_cnt;
    kick();
    wait_verdict(1000, seen, cyc);
    vec++;
    if (!seen || cyc != 109) begin
      miss++; $display("FAIL happy_latency: got seen=%0d cyc=%0d want seen=1 cyc=109", seen, cyc);
    end
    vec++;
    if (req_cnt - br != 33) begin
      miss++; $display("FAIL happy_req_count: got %0d want 33", req_cnt - br);
    end
    for (int i = 0; i < 33 && i < req_cnt - br; i++) begin
      vec++;
      if (req_log[br + i] !== 32'(4 * i)) begin
        miss++; $display("FAIL happy_addr[%0d]: got %h want %h", i, req_log[br + i], 32'(4 * i));
      end
    end
    vec++;
    if (wr_cnt - bw != 33) begin
      miss++; $display("FAIL happy_wr_count: got %0d want 33", wr_cnt - bw);
    end
    for (int j = 0; j < 32 && j < wr_cnt - bw; j++) begin
      vec++;
      if (wr_log[bw + j] !== rom_word(j + 1)) begin
        miss++; $display("FAIL happy_wr[%0d]: got %h want %h", j, wr_log[bw + j], rom_word(j + 1));
      end
    end
    vec++;
    if (wr_log[bw + 32] !== 32'h1) begin
      miss++; $display("FAIL happy_ctrl: got %h want 00000001", wr_log[bw + 32]);
    end
    vec++;
    if ({a_ok, a_fail, a_err, a_lock, a_busy} !== 7'b1000010) begin
      miss++; $display("FAIL happy_verdict: got %b want 1000010", {a_ok, a_fail, a_err, a_lock, a_busy});
    end
  endtask

  task automatic test_bad_magic();
    bit seen; int cyc; int br; int bw;
    do_reset(1'b0);
    magic_word = 32'hDEAD_BEEF;
    mb_delay = 10;
    br = req_cnt; bw = wr_cnt;
    kick();
    wait_verdict(200, seen, cyc);
    repeat (5) @(posedge clk);
    #1;
    vec++;
    if (req_cnt - br != 1 || wr_cnt - bw != 0) begin
      miss++; $display("FAIL magic_traffic: got reads=%0d writes=%0d want reads=1 writes=0", req_cnt - br, wr_cnt - bw);
    end
    vec++;
    if ({a_ok, a_fail, a_err, a_lock, a_busy} !== 7'b0100110) begin
      miss++; $display("FAIL magic_verdict: got %b want 0100110", {a_ok, a_fail, a_err, a_lock, a_busy});
    end
  endtask

  task automatic test_sig_reject();
    bit seen; int cyc; int bw;
    do_reset(1'b0);
    mb_delay = 10;
    mb_ok = 1'b0;
    bw = wr_cnt;
    kick();
    wait_verdict(1000, seen, cyc);
    vec++;
    if (!seen || wr_cnt - bw != 33) begin
      miss++; $display("FAIL sig_writes: got seen=%0d writes=%0d want seen=1 writes=33", seen, wr_cnt - bw);
    end
    vec++;
    if ({a_ok, a_fail, a_err, a_lock, a_busy} !== 7'b0101010) begin
      miss++; $display("FAIL sig_verdict: got %b want 0101010", {a_ok, a_fail, a_err, a_lock, a_busy});
    end
  endtask

  task automatic test_rom_error();
    bit seen; int cyc; int br; int bw;
    do_reset(1'b0);
    mb_delay = 10;
    err_idx = 5;
    br = req_cnt; bw = wr_cnt;
    kick();
    wait_verdict(1000, seen, cyc);
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (!seen || wr_cnt - bw != 4 || req_cnt - br != 6) begin
      miss++; $display("FAIL romerr_traffic: got seen=%0d writes=%0d reads=%0d want 1/4/6", seen, wr_cnt - bw, req_cnt - br);
    end
    for (int j = 0; j < 4 && j < wr_cnt - bw; j++) begin
      vec++;
      if (wr_log[bw + j] !== rom_word(j + 1)) begin
        miss++; $display("FAIL romerr_wr[%0d]: got %h want %h", j, wr_log[bw + j], rom_word(j + 1));
      end
    end
    vec++;
    if ({a_ok, a_fail, a_err, a_lock, a_busy} !== 7'b0110010) begin
      miss++; $display("FAIL romerr_verdict: got %b want 0110010", {a_ok, a_fail, a_err, a_lock, a_busy});
    end
  endtask

  task automatic test_random_latency();
    bit seen; int cyc; int br; int bw;
    do_reset(1'b0);
    br = req_cnt; bw = wr_cnt;
    spur_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    spur_en = 1'b0;
    vec++;
    if (a_busy !== 1'b0 || a_wr !== 1'b0 || req_cnt - br != 0) begin
      miss++; $display("FAIL spurious_idle: got busy=%b wr=%b reads=%0d want 0/0/0", a_busy, a_wr, req_cnt - br);
    end
    rand_lat = 1'b1;
    mb_delay = 10;
    kick();
    wait_verdict(3000, seen, cyc);
    vec++;
    if (!seen || wr_cnt - bw != 33 || req_cnt - br != 33) begin
      miss++; $display("FAIL randlat_traffic: got seen=%0d writes=%0d reads=%0d want 1/33/33", seen, wr_cnt - bw, req_cnt - br);
    end
    for (int j = 0; j < 32 && j < wr_cnt - bw; j++) begin
      vec++;
      if (wr_log[bw + j] !== rom_word(j + 1)) begin
        miss++; $display("FAIL randlat_wr[%0d]: got %h want %h", j, wr_log[bw + j], rom_word(j + 1));
      end
    end
    vec++;
    if ({a_ok, a_fail, a_err, a_lock} !== 6'b100001) begin
      miss++; $display("FAIL randlat_verdict: got %b want 100001", {a_ok, a_fail, a_err, a_lock});
    end
  endtask

  task automatic test_timeout();
    int bw;
    do_reset(1'b1);
    bw = wr_cnt;
    kick();
    repeat (199) @(posedge clk);
    #1;
    vec++;
    if (t_fail !== 1'b0 || t_busy !== 1'b1) begin
      miss++; $display("FAIL timeout_early: got fail=%b busy=%b at 199 want 0/1", t_fail, t_busy);
    end
    @(posedge clk); #1;
    vec++;
    if ({t_ok, t_fail, t_err, t_lock, t_busy} !== 7'b0101110) begin
      miss++; $display("FAIL timeout_verdict: got %b at 200 want 0101110", {t_ok, t_fail, t_err, t_lock, t_busy});
    end
    vec++;
    if (wr_cnt - bw != 33) begin
      miss++; $display("FAIL timeout_writes: got %0d want 33", wr_cnt - bw);
    end
  endtask

  task automatic test_timeout_race();
    do_reset(1'b1);
    mb_delay = 101;
    kick();
    repeat (199) @(posedge clk);
    #1;
    vec++;
    if (t_ok !== 1'b0 || t_fail !== 1'b0) begin
      miss++; $display("FAIL race_early: got ok=%b fail=%b at 199 want 0/0", t_ok, t_fail);
    end
    @(posedge clk); #1;
    vec++;
    if ({t_ok, t_fail, t_err, t_lock, t_busy} !== 7'b1000010) begin
      miss++; $display("FAIL race_verdict: got %b at 200 want 1000010", {t_ok, t_fail, t_err, t_lock, t_busy});
    end
  endtask

  task automatic test_back_to_back();
    bit seen; int br; int bw; int frozen;
    do_reset(1'b0);
    mb_delay = 10;
    bw = wr_cnt;
    kick();
    for (int i = 0; i < 500 && (wr_cnt - bw) < 10; i++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({a_busy, a_ok, a_fail, a_err, a_lock, a_req, a_wr, a_addr, a_wdata} !== 73'h0) begin
      miss++; $display("FAIL abort_outputs: got %h want 0", {a_busy, a_ok, a_fail, a_err, a_lock, a_req, a_wr, a_addr, a_wdata});
    end
    frozen = wr_cnt;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    vec++;
    if (wr_cnt != frozen || frozen - bw != 10 || a_busy !== 1'b0) begin
      miss++; $display("FAIL abort_quiet: got before=%0d extra=%0d busy=%b want 10/0/0", frozen - bw, wr_cnt - frozen, a_busy);
    end
    br = req_cnt; bw = wr_cnt;
    kick();
    seen = 1'b0;
    for (int i = 1; i <= 1000 && !seen; i++) begin
      if (i == 5 || i == 50) start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      if (a_ok || a_fail) seen = 1'b1;
    end
    vec++;
    if (!seen || req_cnt - br != 33 || wr_cnt - bw != 33) begin
      miss++; $display("FAIL restart_traffic: got seen=%0d reads=%0d writes=%0d want 1/33/33", seen, req_cnt - br, wr_cnt - bw);
    end
    for (int j = 0; j < 32 && j < wr_cnt - bw; j++) begin
      vec++;
      if (wr_log[bw + j] !== rom_word(j + 1)) begin
        miss++; $display("FAIL restart_wr[%0d]: got %h want %h", j, wr_log[bw + j], rom_word(j + 1));
      end
    end
    br = req_cnt;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vec++;
    if (req_cnt != br || {a_ok, a_fail, a_err, a_lock, a_busy} !== 7'b1000010) begin
      miss++; $display("FAIL start_after_pass: got reads=%0d state=%b want 0/1000010", req_cnt - br, {a_ok, a_fail, a_err, a_lock, a_busy});
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_bad_magic();
    test_sig_reject();
    test_rom_error();
    test_random_latency();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
